ai_accel_scheduler: RTL and testbench

- Shares the single AI accelerator (MATMUL/CONV2D/RELU/SOFTMAX/POOL engine) between NUM_REQ requesters, such as CPU cores or a DMA engine.
- Accepts one command per requester through valid/ready, picks a winner by round-robin, and pulses the accelerator enable with the opcode.
- Steers the external operand mux through accel_sel, waits for done/error, and returns a status response to the winning requester.
- Sits between the CPU coprocessor interface and the accelerator. The accelerator and the operand mux are instantiated outside this block.

---
 rtl/ai_accel_pkg.sv | 33 +++
 rtl/ai_accel_scheduler_rr_arbiter.sv | 53 +++++
 rtl/ai_accel_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_ai_accel_scheduler.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ai_accel_pkg.sv
// ---------------------------------------------------------------------------
// ai_accel_pkg
// Shared definitions for the AI accelerator scheduler: accelerator opcodes,
// response status codes and the scheduler state encoding.
// ---------------------------------------------------------------------------
package ai_accel_pkg;

  // Accelerator opcodes; anything above OP_MAX is rejected without issue.
  localparam logic [3:0] OP_MATMUL  = 4'd0;
  localparam logic [3:0] OP_CONV2D  = 4'd1;
  localparam logic [3:0] OP_RELU    = 4'd2;
  localparam logic [3:0] OP_SOFTMAX = 4'd3;
  localparam logic [3:0] OP_POOL    = 4'd4;
  localparam logic [3:0] OP_MAX     = 4'd4;

  // Response status codes returned on rsp_status.
  localparam logic [1:0] ST_OK        = 2'd0;
  localparam logic [1:0] ST_ACCEL_ERR = 2'd1;
  localparam logic [1:0] ST_TIMEOUT   = 2'd2;
  localparam logic [1:0] ST_BAD_OP    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } sched_state_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    return op <= OP_MAX;
  endfunction

endpackage

// File: rtl/ai_accel_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. Grants the first asserted request at or
// after ptr, scanning upward and wrapping at NUM_REQ.
//
// Ports:
//   req        in   NUM_REQ  request vector
//   ptr        in   IDX_W    highest-priority index (must be < NUM_REQ)
//   grant      out  NUM_REQ  one-hot grant, zero when no request
//   grant_idx  out  IDX_W    binary index of the granted request
//   grant_any  out  1        at least one request is asserted
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  // Requests rotated so that bit 0 is the requester at ptr.
  logic [NUM_REQ-1:0] req_rot;
  // One extra bit so ptr + offset cannot overflow before the wrap.
  logic [IDX_W:0]     pos;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch;
    // a path that leaves one unassigned would infer a latch.
    grant     = '0;
    grant_idx = '0;
    pos       = '0;

    req_rot   = NUM_REQ'({req, req} >> ptr);
    grant_any = |req_rot;

    // Descending scan so the lowest rotated offset wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) pos = (IDX_W + 1)'(k);
    end

    pos = pos + {1'b0, ptr};
    if (pos >= (IDX_W + 1)'(NUM_REQ)) pos = pos - (IDX_W + 1)'(NUM_REQ);

    if (grant_any) begin
      grant     = NUM_REQ'(1) << pos;
      grant_idx = pos[IDX_W-1:0];
    end
  end

endmodule

// File: rtl/ai_accel_scheduler.sv
// ---------------------------------------------------------------------------
// ai_accel_scheduler
// Shares one AI accelerator between NUM_REQ requesters. One command is
// accepted at a time by round-robin, issued with a single accel_enable pulse,
// and answered with a status response to the winning requester.
//
// Optional feature: define AI_SCHED_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYCLES cycles with a TIMEOUT response. Without it WAIT holds until
// the accelerator reports done or error.
//
// Ports:
//   clk              in   1          system clock, rising edge
//   rst              in   1          synchronous active-high reset
//   req_valid        in   NUM_REQ    per-requester command valid
//   req_op           in   4*NUM_REQ  opcode of requester i in [4i+3:4i]
//   req_ready        out  NUM_REQ    one-hot grant (IDLE only)
//   rsp_valid        out  NUM_REQ    one-hot completion valid
//   rsp_status       out  2          OK / ACCEL_ERR / TIMEOUT / BAD_OP
//   rsp_ready        in   NUM_REQ    per-requester response accept
//   accel_enable     out  1          one-cycle accelerator start pulse
//   accel_operation  out  4          opcode to the accelerator
//   accel_sel        out  SEL_W      operand-bank select for external mux
//   accel_done       in   1          accelerator completion pulse
//   accel_error      in   1          accelerator error pulse
//   busy             out  1          state is not IDLE
//   cmd_count        out  32         accepted commands, wraps
// ---------------------------------------------------------------------------
module ai_accel_scheduler
  import ai_accel_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int SEL_W          = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [4*NUM_REQ-1:0]   req_op,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [1:0]             rsp_status,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic                   accel_enable,
  output logic [3:0]             accel_operation,
  output logic [SEL_W-1:0]       accel_sel,
  input  logic                   accel_done,
  input  logic                   accel_error,
  output logic                   busy,
  output logic [31:0]            cmd_count
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || SEL_W < $clog2(NUM_REQ) || TIMEOUT_CYCLES < 1)
  begin : g_bad_cfg
    $error("ai_accel_scheduler: illegal parameter combination");
  end

  sched_state_t       state, state_nxt;
  logic [SEL_W-1:0]   rr_ptr;
  logic [SEL_W-1:0]   idx_q;
  logic [NUM_REQ-1:0] grant;
  logic [SEL_W-1:0]   grant_idx;
  logic               grant_any;
  logic [3:0]         grant_op;
  logic [1:0]         status_nxt;
  logic               accept;
  logic               rsp_taken;
  logic               tmo_hit;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (SEL_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Opcode presented by the granted requester.
  always_comb begin
    grant_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_op = req_op[4*i +: 4];
    end
  end

  assign accept    = (state == S_IDLE) && !rst && grant_any;
  assign rsp_taken = |(rsp_ready & rsp_valid);

`ifdef AI_SCHED_TIMEOUT_EN
  // Counts WAIT cycles; cleared during ISSUE so it reads 0 on WAIT entry.
  logic [31:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (rst)                   tmo_cnt <= '0;
    else if (state == S_ISSUE) tmo_cnt <= '0;
    else if (state == S_WAIT)  tmo_cnt <= tmo_cnt + 32'd1;
  end

  assign tmo_hit = (state == S_WAIT) && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from the same edge, independent of statement order.
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and next-status logic. Error outranks done, and both outrank
  // the timeout, because they are tested first.
  always_comb begin
    state_nxt  = state;
    status_nxt = rsp_status;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (op_is_legal(grant_op)) begin
            state_nxt = S_ISSUE;
          end else begin
            state_nxt  = S_RESP;
            status_nxt = ST_BAD_OP;
          end
        end
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (accel_error) begin
          state_nxt  = S_RESP;
          status_nxt = ST_ACCEL_ERR;
        end else if (accel_done) begin
          state_nxt  = S_RESP;
          status_nxt = ST_OK;
        end else if (tmo_hit) begin
          state_nxt  = S_RESP;
          status_nxt = ST_TIMEOUT;
        end
      end
      S_RESP: begin
        if (rsp_taken) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Command bookkeeping and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr          <= '0;
      idx_q           <= '0;
      rsp_status      <= ST_OK;
      accel_operation <= '0;
      accel_sel       <= '0;
      cmd_count       <= '0;
    end else begin
      rsp_status <= status_nxt;
      if (accept) begin
        idx_q     <= grant_idx;
        cmd_count <= cmd_count + 32'd1;
        rr_ptr    <= (grant_idx == SEL_W'(NUM_REQ - 1)) ? '0 : grant_idx + SEL_W'(1);
        // Only legal opcodes reach the accelerator; the operand mux and
        // opcode stay put on a rejected command.
        if (op_is_legal(grant_op)) begin
          accel_operation <= grant_op;
          accel_sel       <= grant_idx;
        end
      end
    end
  end

  // Output decode from state. req_ready is forced low during reset so no
  // requester sees a handshake that the reset is about to discard.
  always_comb begin
    req_ready    = '0;
    rsp_valid    = '0;
    accel_enable = 1'b0;
    busy         = (state != S_IDLE);
    unique case (state)
      S_IDLE:  if (!rst) req_ready = grant;
      S_ISSUE: accel_enable = 1'b1;
      S_WAIT:  ;
      S_RESP:  rsp_valid = NUM_REQ'(1) << idx_q;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ai_accel_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ai_accel_scheduler
// Directed bench for ai_accel_scheduler (NUM_REQ=4, SEL_W=2,
// TIMEOUT_CYCLES=8). Inputs change 1 ns after the rising edge and outputs are
// sampled 1-2 ns after it. The timeout scenario follows AI_SCHED_TIMEOUT_EN.
// ---------------------------------------------------------------------------
module tb_ai_accel_scheduler;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [4*NUM_REQ-1:0] req_op;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [1:0]           rsp_status;
  logic [NUM_REQ-1:0]   rsp_ready;
  logic                 accel_enable;
  logic [3:0]           accel_operation;
  logic [SEL_W-1:0]     accel_sel;
  logic                 accel_done;
  logic                 accel_error;
  logic                 busy;
  logic [31:0]          cmd_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ai_accel_scheduler #(
    .NUM_REQ        (NUM_REQ),
    .SEL_W          (SEL_W),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_op          (req_op),
    .req_ready       (req_ready),
    .rsp_valid       (rsp_valid),
    .rsp_status      (rsp_status),
    .rsp_ready       (rsp_ready),
    .accel_enable    (accel_enable),
    .accel_operation (accel_operation),
    .accel_sel       (accel_sel),
    .accel_done      (accel_done),
    .accel_error     (accel_error),
    .busy            (busy),
    .cmd_count       (cmd_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    req_valid   = '0;
    rsp_ready   = '0;
    accel_done  = 1'b0;
    accel_error = 1'b0;
    tick();
    rst = 1'b0;
    settle();
  endtask

  // One full command: handshake, issue (or BAD_OP), completion, response
  // held for one refused cycle, then accepted. keep leaves req_valid high.
  task automatic do_cmd(input string tag, input logic [3:0] mask, input logic [15:0] ops,
                        input int exp_idx, input logic [3:0] exp_op, input int dly,
                        input bit done, input bit err, input logic [1:0] exp_st,
                        input bit keep);
    logic [3:0] onehot;
    onehot    = 4'b0001 << exp_idx;
    req_valid = mask;
    req_op    = ops;
    settle();
    check({tag, ".ready"}, req_ready, onehot);
    tick();
    if (!keep) req_valid = '0;
    settle();
    if (exp_op > 4'd4) begin
      check({tag, ".no_enable"}, accel_enable, 0);
      check({tag, ".bad_valid"}, rsp_valid, onehot);
      check({tag, ".bad_status"}, rsp_status, 3);
    end else begin
      check({tag, ".enable"}, accel_enable, 1);
      check({tag, ".op"}, accel_operation, exp_op);
      check({tag, ".sel"}, accel_sel, exp_idx);
      tick();
      check({tag, ".enable_pulse"}, accel_enable, 0);
      check({tag, ".sel_hold"}, accel_sel, exp_idx);
      repeat (dly - 1) tick();
      check({tag, ".no_early_rsp"}, rsp_valid, 0);
      accel_done  = done;
      accel_error = err;
      tick();
      accel_done  = 1'b0;
      accel_error = 1'b0;
      settle();
      check({tag, ".rsp_valid"}, rsp_valid, onehot);
      check({tag, ".status"}, rsp_status, exp_st);
    end
    rsp_ready = ~onehot;
    tick();
    check({tag, ".rsp_hold"}, rsp_valid, onehot);
    check({tag, ".status_hold"}, rsp_status, exp_st);
    rsp_ready = onehot;
    tick();
    rsp_ready = '0;
    settle();
    check({tag, ".rsp_drop"}, rsp_valid, 0);
    check({tag, ".idle"}, busy, 0);
  endtask

  initial begin
    rst         = 1'b1;
    req_valid   = '0;
    req_op      = '0;
    rsp_ready   = '0;
    accel_done  = 1'b0;
    accel_error = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    settle();

    // Reset state.
    check("rst.req_ready", req_ready, 0);
    check("rst.rsp_valid", rsp_valid, 0);
    check("rst.rsp_status", rsp_status, 0);
    check("rst.enable", accel_enable, 0);
    check("rst.op", accel_operation, 0);
    check("rst.sel", accel_sel, 0);
    check("rst.busy", busy, 0);
    check("rst.cmd_count", cmd_count, 0);

    // Single command: requester 1, RELU, done 3 cycles after enable.
    do_cmd("single", 4'b0010, 16'h0020, 1, 4'd2, 3, 1'b1, 1'b0, 2'd0, 1'b0);
    check("single.cmd_count", cmd_count, 1);

    // Round robin with everyone valid: 0,1,2,3,0,1.
    do_reset();
    for (int n = 0; n < 6; n++) begin
      do_cmd("rr", 4'b1111, 16'h0000, n % 4, 4'd0, 2, 1'b1, 1'b0, 2'd0, 1'b1);
    end
    req_valid = '0;
    check("rr.cmd_count", cmd_count, 6);

    // Bad opcode from requester 2, then a legal CONV2D from requester 3.
    do_cmd("badop", 4'b0100, 16'h0700, 2, 4'd7, 0, 1'b0, 1'b0, 2'd3, 1'b0);
    check("badop.cmd_count", cmd_count, 7);
    check("badop.op_untouched", accel_operation, 0);
    do_cmd("after_bad", 4'b1000, 16'h1000, 3, 4'd1, 2, 1'b1, 1'b0, 2'd0, 1'b0);
    check("after_bad.cmd_count", cmd_count, 8);

    // Error and done together: error wins.
    do_cmd("errpri", 4'b0001, 16'h0003, 0, 4'd3, 1, 1'b1, 1'b1, 2'd1, 1'b0);
    accel_done = 1'b1;
    tick();
    accel_done = 1'b0;
    settle();
    check("idle_done.busy", busy, 0);
    check("idle_done.rsp_valid", rsp_valid, 0);
    check("idle_done.enable", accel_enable, 0);
    check("idle_done.cmd_count", cmd_count, 9);
    do_cmd("erronly", 4'b0010, 16'h0040, 1, 4'd4, 2, 1'b0, 1'b1, 2'd1, 1'b0);

    // Pointer is 2; requester 0 alone wins after wrapping.
    req_valid = 4'b0001;
    req_op    = 16'h0000;
    settle();
    check("tmo.ready_wrap", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    check("tmo.enable", accel_enable, 1);
    tick();
`ifdef AI_SCHED_TIMEOUT_EN
    repeat (7) tick();
    check("tmo.no_early_rsp", rsp_valid, 0);
    tick();
    check("tmo.rsp_valid", rsp_valid, 4'b0001);
    check("tmo.status", rsp_status, 2);
    accel_done = 1'b1;
    tick();
    accel_done = 1'b0;
    settle();
    check("tmo.late_done_valid", rsp_valid, 4'b0001);
    check("tmo.late_done_status", rsp_status, 2);
`else
    repeat (40) tick();
    check("notmo.still_wait", rsp_valid, 0);
    check("notmo.busy", busy, 1);
    accel_done = 1'b1;
    tick();
    accel_done = 1'b0;
    settle();
    check("notmo.rsp_valid", rsp_valid, 4'b0001);
    check("notmo.status", rsp_status, 0);
`endif
    rsp_ready = 4'b0001;
    tick();
    rsp_ready = '0;
    settle();
    check("tmo.idle", busy, 0);
    check("tmo.cmd_count", cmd_count, 11);

    // Reset while waiting on requester 2's command.
    req_valid = 4'b0100;
    req_op    = 16'h0100;
    settle();
    check("rstwait.ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    tick();
    tick();
    check("rstwait.in_wait", busy, 1);
    check("rstwait.sel", accel_sel, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    check("rstwait.busy", busy, 0);
    check("rstwait.rsp_valid", rsp_valid, 0);
    check("rstwait.status", rsp_status, 0);
    check("rstwait.enable", accel_enable, 0);
    check("rstwait.op", accel_operation, 0);
    check("rstwait.sel0", accel_sel, 0);
    check("rstwait.cmd_count", cmd_count, 0);
    check("rstwait.req_ready", req_ready, 0);
    accel_done = 1'b1;
    tick();
    accel_done = 1'b0;
    repeat (2) tick();
    check("rstwait.no_rsp", rsp_valid, 0);
    check("rstwait.still_idle", busy, 0);
    req_valid = 4'b1111;
    settle();
    check("rstwait.next_grant", req_ready, 4'b0001);
    req_valid = '0;
    settle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
